// File: rtl/lsu.sv
// Load/store unit: initiator side of the dmem port.
//
// Takes one core load/store request at a time over a valid/ready handshake
// and turns it into word-aligned dmem accesses. An access that crosses a word
// boundary becomes two beats (or faults when MISALIGNED_SPLIT = 0). When the
// access completes, the unit issues a one-cycle response pulse. For loads the
// pulse carries the sign- or zero-extended data.
//
// Ports
//   i_clk, i_rst            clock (rising edge), asynchronous active-high reset
//   i_req_valid/o_req_ready request handshake; ready only while idle
//   i_req_we                1 = store, 0 = load
//   i_req_addr              byte address
//   i_req_wdata             store data, LSB-justified
//   i_req_size              00 byte, 01 half, 10 word, 11 reserved (faults)
//   i_req_unsigned          load zero-extends when 1, sign-extends when 0
//   o_resp_valid            one-cycle completion pulse
//   o_resp_rdata            extended load data; 0 for stores and faults
//   o_resp_fault            reserved size, or crossing access with splitting off
//   o_mem_we/addr/wdata/wstrb  dmem request, word aligned, byte-lane shifted
//   i_mem_rdata             dmem read data, combinational from o_mem_addr
module lsu #(
    parameter bit MISALIGNED_SPLIT = 1'b1,
    localparam int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    input  logic [1:0]      i_req_size,
    input  logic            i_req_unsigned,
    output logic            o_resp_valid,
    output logic [XLEN-1:0] o_resp_rdata,
    output logic            o_resp_fault,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [3:0]      o_mem_wstrb,
    input  logic [XLEN-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_next;

    logic            accept;
    logic [2:0]      req_end;
    logic            req_cross;
    logic            req_fault;

    logic            we_q, unsigned_q, cross_q, fault_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q, wdata_q, lo_q, hi_q;

    logic [1:0]      off;
    logic [4:0]      shamt;
    logic [7:0]      lane_mask;
    logic [XLEN-1:0] word_base;
    logic [XLEN-1:0] load_window;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            default: return 8'h0f;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                    input logic [1:0]      size,
                                                    input logic            zext);
        case (size)
            2'b00:   return zext ? {24'b0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
            2'b01:   return zext ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign accept    = i_req_valid && (state == IDLE);
    // Ending byte position past the word means a second beat is needed.
    assign req_end   = {1'b0, i_req_addr[1:0]} + byte_count(i_req_size);
    assign req_cross = (req_end > 3'd4);
    assign req_fault = (i_req_size == 2'b11) || (req_cross && !MISALIGNED_SPLIT);

    assign off         = addr_q[1:0];
    assign shamt       = {off, 3'b000};
    assign lane_mask   = size_mask(size_q) << off;
    assign word_base   = {addr_q[XLEN-1:2], 2'b00};
    // hi_q is cleared on accept, so a single-beat load shifts in zeros.
    assign load_window = 32'({hi_q, lo_q} >> shamt);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            cross_q    <= 1'b0;
            fault_q    <= 1'b0;
            size_q     <= 2'b00;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q       <= i_req_we;
                unsigned_q <= i_req_unsigned;
                cross_q    <= req_cross;
                fault_q    <= req_fault;
                size_q     <= i_req_size;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
            hi_q    <= '0;
        end
        if (state == ACC0 && !we_q) lo_q <= i_mem_rdata;
        if (state == ACC1 && !we_q) hi_q <= i_mem_rdata;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_fault ? RESP : ACC0;
            ACC0:    state_next = cross_q ? ACC1 : RESP;
            ACC1:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The dmem port is decoded from registered state only, never from i_req_*.
    always_comb begin
        o_req_ready  = (state == IDLE);
        o_resp_valid = 1'b0;
        o_resp_rdata = '0;
        o_resp_fault = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_mem_wstrb  = 4'b0000;
        case (state)
            ACC0: begin
                o_mem_addr = word_base;
                if (we_q) begin
                    o_mem_we    = 1'b1;
                    o_mem_wstrb = lane_mask[3:0];
                    o_mem_wdata = wdata_q << shamt;
                end
            end
            ACC1: begin
                o_mem_addr = word_base + 32'd4;
                if (we_q) begin
                    o_mem_we    = 1'b1;
                    o_mem_wstrb = lane_mask[7:4];
                    o_mem_wdata = wdata_q >> (6'd32 - {1'b0, shamt});
                end
            end
            RESP: begin
                o_resp_valid = 1'b1;
                o_resp_fault = fault_q;
                if (!we_q && !fault_q)
                    o_resp_rdata = load_extend(load_window, size_q, unsigned_q);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;

    logic        req_ready, resp_valid, resp_fault, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic        z_req_ready, z_resp_valid, z_resp_fault, z_mem_we;
    logic [31:0] z_resp_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;
    logic [3:0]  z_mem_wstrb;

    logic [31:0] mem [0:15];

    int checks = 0;
    int failures = 0;

    // Per-request capture
    int          n_beats, resp_cnt, r_lat, z_cnt, z_lat;
    logic [31:0] b_addr [2];
    logic [31:0] b_wdata [2];
    logic [3:0]  b_strb [2];
    logic [31:0] r_rdata, z_rdata;
    logic        r_fault, z_fault, z_we, busy_ready;

    always #5 clk = ~clk;

    lsu #(.MISALIGNED_SPLIT(1'b1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_fault(resp_fault),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_wstrb(mem_wstrb), .i_mem_rdata(mem_rdata)
    );

    lsu #(.MISALIGNED_SPLIT(1'b0)) dut_nosplit (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(z_req_ready),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .o_resp_valid(z_resp_valid), .o_resp_rdata(z_resp_rdata), .o_resp_fault(z_resp_fault),
        .o_mem_we(z_mem_we), .o_mem_addr(z_mem_addr), .o_mem_wdata(z_mem_wdata),
        .o_mem_wstrb(z_mem_wstrb), .i_mem_rdata(z_mem_rdata)
    );

    // Small byte-strobed memory; addresses alias on bits [5:2].
    assign mem_rdata   = mem[mem_addr[5:2]];
    assign z_mem_rdata = mem[z_mem_addr[5:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
        n_beats = 0; resp_cnt = 0; r_lat = 0; z_cnt = 0; z_lat = 0;
        r_rdata = 'x; z_rdata = 'x; r_fault = 1'bx; z_fault = 1'bx;
        z_we = 1'b0; busy_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_we) begin
                if (n_beats < 2) begin
                    b_addr[n_beats] = mem_addr; b_wdata[n_beats] = mem_wdata;
                    b_strb[n_beats] = mem_wstrb;
                end
                n_beats++;
            end
            if (req_ready && resp_cnt == 0) busy_ready = 1'b1;
            if (resp_valid) begin
                if (resp_cnt == 0) begin r_lat = c; r_rdata = resp_rdata; r_fault = resp_fault; end
                resp_cnt++;
            end
            if (z_resp_valid) begin
                if (z_cnt == 0) begin z_lat = c; z_rdata = z_resp_rdata; z_fault = z_resp_fault; end
                z_cnt++;
            end
            if (z_mem_we) z_we = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if ({resp_valid, resp_fault, resp_rdata} !== 34'h0) begin failures++; $display("FAIL reset_resp got=%b/%b/%h exp=0", resp_valid, resp_fault, resp_rdata); end
        checks++; if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== 69'h0) begin failures++; $display("FAIL reset_mem got we=%b addr=%h wdata=%h strb=%b exp=0", mem_we, mem_addr, mem_wdata, mem_wstrb); end
        rst = 1'b0;
    endtask

    task automatic test_word;
        run(1'b1, 32'h0, 32'h11223344, 2'b10, 1'b0);
        checks++; if (n_beats !== 1) begin failures++; $display("FAIL word_st_beats got=%0d exp=1", n_beats); end
        checks++; if ({b_addr[0], b_strb[0], b_wdata[0]} !== {32'h0, 4'b1111, 32'h11223344}) begin failures++; $display("FAIL word_st_beat got addr=%h strb=%b wdata=%h exp 0/1111/11223344", b_addr[0], b_strb[0], b_wdata[0]); end
        checks++; if ({resp_cnt, r_lat, r_fault, r_rdata} !== {32'd1, 32'd2, 1'b0, 32'h0}) begin failures++; $display("FAIL word_st_resp got cnt=%0d lat=%0d fault=%b rdata=%h exp 1/2/0/0", resp_cnt, r_lat, r_fault, r_rdata); end
        checks++; if (busy_ready !== 1'b0) begin failures++; $display("FAIL word_st_busy_ready got=%b exp=0", busy_ready); end
        run(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
        checks++; if (n_beats !== 0) begin failures++; $display("FAIL word_ld_we got=%0d exp=0", n_beats); end
        checks++; if ({r_lat, r_rdata} !== {32'd2, 32'h11223344}) begin failures++; $display("FAIL word_ld got lat=%0d rdata=%h exp 2/11223344", r_lat, r_rdata); end
    endtask

    task automatic test_half;
        run(1'b1, 32'h6, 32'haabbccdd, 2'b01, 1'b0);
        checks++; if ({n_beats, b_addr[0], b_strb[0], b_wdata[0]} !== {32'd1, 32'h4, 4'b1100, 32'hccdd0000}) begin failures++; $display("FAIL half_st got n=%0d addr=%h strb=%b wdata=%h exp 1/4/1100/ccdd0000", n_beats, b_addr[0], b_strb[0], b_wdata[0]); end
        run(1'b0, 32'h6, 32'h0, 2'b01, 1'b0);
        checks++; if ({r_lat, r_rdata} !== {32'd2, 32'hffffccdd}) begin failures++; $display("FAIL half_ld_s got lat=%0d rdata=%h exp 2/ffffccdd", r_lat, r_rdata); end
        run(1'b0, 32'h6, 32'h0, 2'b01, 1'b1);
        checks++; if (r_rdata !== 32'h0000ccdd) begin failures++; $display("FAIL half_ld_u got=%h exp=0000ccdd", r_rdata); end
    endtask

    task automatic test_byte;
        run(1'b1, 32'h9, 32'h12345678, 2'b00, 1'b0);
        checks++; if ({n_beats, b_addr[0], b_strb[0], b_wdata[0]} !== {32'd1, 32'h8, 4'b0010, 32'h34567800}) begin failures++; $display("FAIL byte_st got n=%0d addr=%h strb=%b wdata=%h exp 1/8/0010/34567800", n_beats, b_addr[0], b_strb[0], b_wdata[0]); end
        run(1'b0, 32'h9, 32'h0, 2'b00, 1'b0);
        checks++; if (r_rdata !== 32'h00000078) begin failures++; $display("FAIL byte_ld_pos got=%h exp=00000078", r_rdata); end
        run(1'b1, 32'h9, 32'h00000080, 2'b00, 1'b0);
        run(1'b0, 32'h9, 32'h0, 2'b00, 1'b0);
        checks++; if (r_rdata !== 32'hffffff80) begin failures++; $display("FAIL byte_ld_neg got=%h exp=ffffff80", r_rdata); end
        run(1'b0, 32'h9, 32'h0, 2'b00, 1'b1);
        checks++; if (r_rdata !== 32'h00000080) begin failures++; $display("FAIL byte_ld_u got=%h exp=00000080", r_rdata); end
    endtask

    task automatic test_split;
        run(1'b1, 32'h3, 32'hdeadbeef, 2'b10, 1'b0);
        checks++; if (n_beats !== 2) begin failures++; $display("FAIL split_st_beats got=%0d exp=2", n_beats); end
        checks++; if ({b_addr[0], b_strb[0], b_wdata[0]} !== {32'h0, 4'b1000, 32'hef000000}) begin failures++; $display("FAIL split_st_b0 got addr=%h strb=%b wdata=%h exp 0/1000/ef000000", b_addr[0], b_strb[0], b_wdata[0]); end
        checks++; if ({b_addr[1], b_strb[1], b_wdata[1]} !== {32'h4, 4'b0111, 32'h00deadbe}) begin failures++; $display("FAIL split_st_b1 got addr=%h strb=%b wdata=%h exp 4/0111/00deadbe", b_addr[1], b_strb[1], b_wdata[1]); end
        checks++; if ({resp_cnt, r_lat} !== {32'd1, 32'd3}) begin failures++; $display("FAIL split_st_resp got cnt=%0d lat=%0d exp 1/3", resp_cnt, r_lat); end
        run(1'b0, 32'h3, 32'h0, 2'b10, 1'b0);
        checks++; if ({r_lat, r_fault, r_rdata} !== {32'd3, 1'b0, 32'hdeadbeef}) begin failures++; $display("FAIL split_ld got lat=%0d fault=%b rdata=%h exp 3/0/deadbeef", r_lat, r_fault, r_rdata); end
        checks++; if ({z_lat, z_fault, z_rdata, z_we} !== {32'd1, 1'b1, 32'h0, 1'b0}) begin failures++; $display("FAIL nosplit_ld3 got lat=%0d fault=%b rdata=%h we=%b exp 1/1/0/0", z_lat, z_fault, z_rdata, z_we); end
        run(1'b1, 32'hb, 32'h00001234, 2'b01, 1'b0);
        checks++; if ({n_beats, b_strb[0], b_wdata[0], b_addr[1], b_strb[1], b_wdata[1]} !== {32'd2, 4'b1000, 32'h34000000, 32'hc, 4'b0001, 32'h00000012}) begin failures++; $display("FAIL split_half_st got n=%0d s0=%b w0=%h a1=%h s1=%b w1=%h", n_beats, b_strb[0], b_wdata[0], b_addr[1], b_strb[1], b_wdata[1]); end
        run(1'b0, 32'hb, 32'h0, 2'b01, 1'b0);
        checks++; if ({r_lat, r_rdata} !== {32'd3, 32'h00001234}) begin failures++; $display("FAIL split_half_ld got lat=%0d rdata=%h exp 3/00001234", r_lat, r_rdata); end
    endtask

    task automatic test_fault;
        // Bytes 2..5 hold 22, ef, be, ad after the preceding stores.
        run(1'b0, 32'h2, 32'h0, 2'b10, 1'b0);
        checks++; if ({r_lat, r_fault, r_rdata} !== {32'd3, 1'b0, 32'hadbeef22}) begin failures++; $display("FAIL split_ld2 got lat=%0d fault=%b rdata=%h exp 3/0/adbeef22", r_lat, r_fault, r_rdata); end
        checks++; if ({z_cnt, z_lat, z_fault, z_rdata} !== {32'd1, 32'd1, 1'b1, 32'h0}) begin failures++; $display("FAIL nosplit_ld2 got cnt=%0d lat=%0d fault=%b rdata=%h exp 1/1/1/0", z_cnt, z_lat, z_fault, z_rdata); end
        run(1'b1, 32'h2, 32'h55667788, 2'b10, 1'b0);
        checks++; if (z_we !== 1'b0) begin failures++; $display("FAIL nosplit_st_we got=%b exp=0", z_we); end
        run(1'b1, 32'h0, 32'h000000ff, 2'b11, 1'b0);
        checks++; if ({n_beats, r_lat, r_fault, r_rdata} !== {32'd0, 32'd1, 1'b1, 32'h0}) begin failures++; $display("FAIL size11_st got n=%0d lat=%0d fault=%b rdata=%h exp 0/1/1/0", n_beats, r_lat, r_fault, r_rdata); end
        checks++; if ({z_lat, z_fault, z_we} !== {32'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL nosplit_size11 got lat=%0d fault=%b we=%b exp 1/1/0", z_lat, z_fault, z_we); end
        run(1'b0, 32'h4, 32'h0, 2'b11, 1'b0);
        checks++; if ({r_fault, r_rdata} !== {1'b1, 32'h0}) begin failures++; $display("FAIL size11_ld got fault=%b rdata=%h exp 1/0", r_fault, r_rdata); end
    endtask

    task automatic test_back_to_back;
        int cnt = 0;
        logic hit2 = 1'b0, hit5 = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 4) req_valid = 1'b0;
            if (resp_valid) begin
                cnt++;
                if (c == 2) hit2 = 1'b1;
                if (c == 5) hit5 = 1'b1;
            end
        end
        checks++; if ({cnt, hit2, hit5} !== {32'd2, 1'b1, 1'b1}) begin failures++; $display("FAIL b2b_resp got cnt=%0d at2=%b at5=%b exp 2/1/1", cnt, hit2, hit5); end
    endtask

    task automatic test_reset_midop;
        int seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1; req_wdata = 32'h01020304;
        req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({mem_we, mem_addr} !== {1'b1, 32'h4}) begin failures++; $display("FAIL midrst_acc1 got we=%b addr=%h exp 1/4", mem_we, mem_addr); end
        rst = 1'b1;
        #1;
        checks++; if ({mem_we, req_ready, resp_valid} !== 3'b010) begin failures++; $display("FAIL midrst_async got we=%b ready=%b resp=%b exp 0/1/0", mem_we, req_ready, resp_valid); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_noresp got=%0d exp=0", seen); end

        run(1'b1, 32'hfffffffd, 32'hcafef00d, 2'b10, 1'b0);
        checks++; if ({n_beats, b_addr[0], b_strb[0], b_wdata[0]} !== {32'd2, 32'hfffffffc, 4'b1110, 32'hfef00d00}) begin failures++; $display("FAIL wrap_b0 got n=%0d addr=%h strb=%b wdata=%h exp 2/fffffffc/1110/fef00d00", n_beats, b_addr[0], b_strb[0], b_wdata[0]); end
        checks++; if ({b_addr[1], b_strb[1], b_wdata[1]} !== {32'h0, 4'b0001, 32'h000000ca}) begin failures++; $display("FAIL wrap_b1 got addr=%h strb=%b wdata=%h exp 0/0001/000000ca", b_addr[1], b_strb[1], b_wdata[1]); end
        run(1'b0, 32'hfffffffd, 32'h0, 2'b10, 1'b0);
        checks++; if ({r_lat, r_rdata} !== {32'd3, 32'hcafef00d}) begin failures++; $display("FAIL wrap_ld got lat=%0d rdata=%h exp 3/cafef00d", r_lat, r_rdata); end
    endtask

    initial begin
        test_reset;
        test_word;
        test_half;
        test_byte;
        test_split;
        test_fault;
        test_back_to_back;
        test_reset_midop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
